// File: rtl/adt7420_temp_to_bcd.sv
// adt7420_temp_to_bcd
// Turns a 13-bit ADT7420 temperature word into three packed BCD digits of |T|
// in tenths of a degree {tens, ones, tenths}. It also reports the sign and a
// saturation flag. Conversion is sequential: one scaling cycle, ten
// double-dabble cycles, then one cycle to publish the result.
module adt7420_temp_to_bcd #(
  parameter int FRAC_BITS = 4,
  parameter int CLAMP_MAX = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raw_temp,
  input  logic        sample_valid,
  output logic [11:0] bcd_temp,
  output logic        negative,
  output logic        over_range,
  output logic        bcd_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCALE   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] t_q, t_d;             // captured two's-complement reading
  logic        neg_q, neg_d;         // sign of the reading being converted
  logic        ovf_q, ovf_d;         // magnitude was saturated to CLAMP_MAX
  logic [9:0]  bin_q, bin_d;         // binary tenths being shifted out
  logic [11:0] bcd_q, bcd_d;         // BCD accumulator being shifted in
  logic [3:0]  cnt_q, cnt_d;         // shift count within CONVERT
  logic [11:0] bcd_temp_q, bcd_temp_d;
  logic        negative_q, negative_d;
  logic        over_range_q, over_range_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        busy_q, busy_d;

  // Bits [2:0] of the sensor word are status/flag bits and carry no temperature.
  logic unused_raw_bits;
  assign unused_raw_bits = ^raw_temp[2:0];

  // Scaling path. The magnitude is 13 bits unsigned, so -4096 maps to 4096 without wrapping.
  logic [12:0] mag;
  logic [15:0] prod;
  logic [15:0] tenths;
  logic        clamp;

  assign mag    = t_q[12] ? (~t_q + 13'd1) : t_q;
  assign prod   = {3'b000, mag} * 16'd10;
  assign tenths = prod >> FRAC_BITS;
  assign clamp  = (tenths > 16'(CLAMP_MAX));

  // Add-3 correction for each BCD digit, applied before every shift.
  logic [11:0] bcd_adj;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // State register and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      t_q          <= '0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      bcd_temp_q   <= 12'h000;
      negative_q   <= 1'b0;
      over_range_q <= 1'b0;
      bcd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      neg_q        <= neg_d;
      ovf_q        <= ovf_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      bcd_temp_q   <= bcd_temp_d;
      negative_q   <= negative_d;
      over_range_q <= over_range_d;
      bcd_valid_q  <= bcd_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and datapath control for the IDLE -> SCALE -> CONVERT -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    neg_d        = neg_q;
    ovf_d        = ovf_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    bcd_temp_d   = bcd_temp_q;
    negative_d   = negative_q;
    over_range_d = over_range_q;
    bcd_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          t_d     = raw_temp[15:3];
          state_d = SCALE;
        end
      end
      SCALE: begin
        neg_d   = t_q[12];
        ovf_d   = clamp;
        bin_d   = clamp ? 10'(CLAMP_MAX) : tenths[9:0];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_temp_d   = bcd_q;
        negative_d   = neg_q;
        over_range_d = ovf_q;
        bcd_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Busy covers the whole conversion plus the cycle in which bcd_valid is shown.
    busy_d = (state_d != IDLE) || bcd_valid_d;
  end

  assign bcd_temp   = bcd_temp_q;
  assign negative   = negative_q;
  assign over_range = over_range_q;
  assign bcd_valid  = bcd_valid_q;
  assign busy       = busy_q;

endmodule
